maze_game_core: RTL and testbench
=================================

MAZE_GAME_CORE -- requirements
Module: maze_game_core

Interface
REQ-001 Parameter MAP_W, default 30, maze columns (bits per map row).
REQ-002 Parameter MAP_H, default 21, maze rows.
REQ-003 Parameter START_X / START_Y, default 0 / 20, player start cell.
REQ-004 Parameter GOAL_X / GOAL_Y, default 29 / 0, winning cell.
REQ-005 Parameter SHOW_EASY / SHOW_MED / SHOW_HARD, default 1000000 / 500000 / 250000, map-preview cycles per difficulty.
REQ-006 Derived widths: XW = $clog2(MAP_W), YW = $clog2(MAP_H).
REQ-007 clk  input  1  system clock; all state updates on its rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 mv_up, mv_down, mv_left, mv_right  input  1 each  single-cycle move pulses, already debounced.
REQ-010 sel  input  1  single-cycle select pulse.
REQ-011 map_addr  output  YW  map ROM row address.
REQ-012 map_row  input  MAP_W  ROM row data, valid exactly 1 cycle after map_addr changes; bit x = 1 means wall.
REQ-013 player_x  output  XW; player_y  output  YW  current player cell.
REQ-014 state  output  3  MENU=0, SHOW=1, PLAY=2, CHECK=3, LOST=4, WON=5.
REQ-015 difficulty  output  2  easy=0, medium=1, hard=2.
REQ-016 show_map  output  1  high only while state==SHOW.
REQ-017 lost, won  output  1 each  high only in LOST / WON respectively.
REQ-018 move_count  output  16  accepted moves in current game.

Function
REQ-019 MENU: mv_up decrements difficulty, mv_down increments it, both wrap (0->2 on up, 2->0 on down); mv_left/mv_right ignored.
REQ-020 MENU + sel: load preview counter with SHOW_* for current difficulty, clear move_count, place player at (START_X, START_Y), go to SHOW next cycle.
REQ-021 SHOW: counter decrements by 1 per cycle; on the cycle it reads 1, go to PLAY; SHOW therefore lasts exactly SHOW_* cycles; move pulses and sel ignored.
REQ-022 PLAY: on a move pulse compute target cell; simultaneous pulses resolved by priority up > down > left > right; only the winner is considered.
REQ-023 Target outside 0..MAP_W-1 / 0..MAP_H-1 (including x=0 left, y=0 up): pulse ignored, no count, stay in PLAY.
REQ-024 In-bounds target: latch target, drive map_addr = target_y, go to CHECK.
REQ-025 CHECK lasts exactly 1 cycle; evaluate map_row[target_x]: if 1, go to LOST, position unchanged; else update player to target, increment move_count (saturate at 65535), then go to WON if target == (GOAL_X, GOAL_Y), else PLAY.
REQ-026 Move pulses and sel arriving during CHECK are dropped, not queued.
REQ-027 LOST or WON + sel: go to MENU, player returns to start, difficulty retained, move_count held until next game start.
REQ-028 Outside CHECK, map_addr = player_y.
REQ-029 sel in PLAY is ignored.
REQ-030 Outputs lost, won, show_map decode directly from registered state; no combinational path from inputs to any output.

Reset
REQ-031 reset asserted at any time, including mid-SHOW or during CHECK, forces within the same edge: state=MENU, difficulty=0, player=(START_X,START_Y), move_count=0, preview counter=0, map_addr=START_Y, lost=won=show_map=0.
REQ-032 First operational edge is the first rising clk after reset deasserts.

Verification
REQ-033 Reset, mv_down x4 in MENU -> difficulty 1,2,0,1; mv_up from 0 -> 2.
REQ-034 SHOW_EASY=10, sel in MENU -> show_map high exactly 10 cycles, then state=2; mv_right during SHOW -> player_x stays 0.
REQ-035 PLAY at (0,20), row 20 = all zeros, mv_right -> state=3 one cycle with map_addr=20, then player_x=1, move_count=1; mv_left at x=0 -> ignored, move_count unchanged.
REQ-036 Row 19 bit 0 = 1, player (0,20), mv_up -> state=3 then 4, lost=1, player stays (0,20); sel -> state=0, player=(0,20).
REQ-037 mv_up and mv_right same cycle, path open above -> only y decrements; reaching (29,0) -> won=1, state=5.
REQ-038 reset pulse while state=3 -> next sampled state=0, all outputs at REQ-031 values.

Source files
------------

// File: rtl/maze_game_core.sv
// maze_game_core
//   Control core for a hidden-maze game: difficulty menu, timed map preview,
//   step-by-step movement checked against a wall map ROM, win/lose handling.
//
// Ports
//   clk         system clock, rising-edge active
//   reset       asynchronous, active-high reset
//   mv_up/down/left/right  single-cycle debounced move pulses
//   sel         single-cycle select pulse
//   map_addr    ROM row address (target row during CHECK, player row otherwise)
//   map_row     ROM row data, bit x = 1 means wall
//   player_x/y  current player cell
//   state       MENU=0 SHOW=1 PLAY=2 CHECK=3 LOST=4 WON=5
//   difficulty  easy=0 medium=1 hard=2
//   show_map    high while previewing the map
//   lost, won   end-of-game flags
//   move_count  accepted moves in the current game (saturating)
module maze_game_core #(
   parameter int MAP_W     = 30,
   parameter int MAP_H     = 21,
   parameter int START_X   = 0,
   parameter int START_Y   = 20,
   parameter int GOAL_X    = 29,
   parameter int GOAL_Y    = 0,
   parameter int SHOW_EASY = 1000000,
   parameter int SHOW_MED  = 500000,
   parameter int SHOW_HARD = 250000,
   localparam int XW = $clog2(MAP_W),
   localparam int YW = $clog2(MAP_H)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mv_up,
   input  logic             mv_down,
   input  logic             mv_left,
   input  logic             mv_right,
   input  logic             sel,
   output logic [YW-1:0]    map_addr,
   input  logic [MAP_W-1:0] map_row,
   output logic [XW-1:0]    player_x,
   output logic [YW-1:0]    player_y,
   output logic [2:0]       state,
   output logic [1:0]       difficulty,
   output logic             show_map,
   output logic             lost,
   output logic             won,
   output logic [15:0]      move_count
);

   localparam logic [2:0] S_MENU  = 3'd0;
   localparam logic [2:0] S_SHOW  = 3'd1;
   localparam logic [2:0] S_PLAY  = 3'd2;
   localparam logic [2:0] S_CHECK = 3'd3;
   localparam logic [2:0] S_LOST  = 3'd4;
   localparam logic [2:0] S_WON   = 3'd5;

   localparam int SHOW_MAX =
      (SHOW_EASY > SHOW_MED) ? ((SHOW_EASY > SHOW_HARD) ? SHOW_EASY : SHOW_HARD)
                             : ((SHOW_MED  > SHOW_HARD) ? SHOW_MED  : SHOW_HARD);
   localparam int CW = $clog2(SHOW_MAX + 1);

   logic [2:0]    state_q, state_d;
   logic [1:0]    diff_q,  diff_d;
   logic [XW-1:0] px_q,    px_d;
   logic [YW-1:0] py_q,    py_d;
   logic [XW-1:0] tx_q,    tx_d;
   logic [YW-1:0] ty_q,    ty_d;
   logic [15:0]   mc_q,    mc_d;
   logic [CW-1:0] cnt_q,   cnt_d;

   logic          mv_ok;
   logic [XW-1:0] mv_x;
   logic [YW-1:0] mv_y;
   logic [CW-1:0] show_len;

   // Only the highest-priority pulse is considered; if its target is off the
   // grid the whole request is dropped, lower-priority pulses do not step in.
   always_comb begin
      mv_ok = 1'b0;
      mv_x  = px_q;
      mv_y  = py_q;
      if (mv_up) begin
         if (py_q != '0) begin
            mv_ok = 1'b1;
            mv_y  = py_q - YW'(1);
         end
      end else if (mv_down) begin
         if (py_q != YW'(MAP_H - 1)) begin
            mv_ok = 1'b1;
            mv_y  = py_q + YW'(1);
         end
      end else if (mv_left) begin
         if (px_q != '0) begin
            mv_ok = 1'b1;
            mv_x  = px_q - XW'(1);
         end
      end else if (mv_right) begin
         if (px_q != XW'(MAP_W - 1)) begin
            mv_ok = 1'b1;
            mv_x  = px_q + XW'(1);
         end
      end
   end

   always_comb begin
      case (diff_q)
         2'd1:    show_len = CW'(SHOW_MED);
         2'd2:    show_len = CW'(SHOW_HARD);
         default: show_len = CW'(SHOW_EASY);
      endcase
   end

   always_comb begin
      state_d = state_q;
      diff_d  = diff_q;
      px_d    = px_q;
      py_d    = py_q;
      tx_d    = tx_q;
      ty_d    = ty_q;
      mc_d    = mc_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_MENU: begin
            if (sel) begin
               cnt_d   = show_len;
               mc_d    = '0;
               px_d    = XW'(START_X);
               py_d    = YW'(START_Y);
               state_d = S_SHOW;
            end else if (mv_up) begin
               diff_d = (diff_q == 2'd0) ? 2'd2 : diff_q - 2'd1;
            end else if (mv_down) begin
               diff_d = (diff_q >= 2'd2) ? 2'd0 : diff_q + 2'd1;
            end
         end
         S_SHOW: begin
            // Counter holds the remaining preview cycles including the current one.
            if (cnt_q <= CW'(1)) begin
               cnt_d   = '0;
               state_d = S_PLAY;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_PLAY: begin
            if (mv_ok) begin
               tx_d    = mv_x;
               ty_d    = mv_y;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (map_row[tx_q]) begin
               state_d = S_LOST;
            end else begin
               px_d = tx_q;
               py_d = ty_q;
               if (mc_q != 16'hFFFF) mc_d = mc_q + 16'd1;
               if (tx_q == XW'(GOAL_X) && ty_q == YW'(GOAL_Y)) state_d = S_WON;
               else                                              state_d = S_PLAY;
            end
         end
         S_LOST, S_WON: begin
            if (sel) begin
               px_d    = XW'(START_X);
               py_d    = YW'(START_Y);
               state_d = S_MENU;
            end
         end
         default: state_d = S_MENU;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_MENU;
         diff_q  <= '0;
         px_q    <= XW'(START_X);
         py_q    <= YW'(START_Y);
         tx_q    <= XW'(START_X);
         ty_q    <= YW'(START_Y);
         mc_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         diff_q  <= diff_d;
         px_q    <= px_d;
         py_q    <= py_d;
         tx_q    <= tx_d;
         ty_q    <= ty_d;
         mc_q    <= mc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign map_addr   = (state_q == S_CHECK) ? ty_q : py_q;
   assign player_x   = px_q;
   assign player_y   = py_q;
   assign state      = state_q;
   assign difficulty = diff_q;
   assign show_map   = (state_q == S_SHOW);
   assign lost       = (state_q == S_LOST);
   assign won        = (state_q == S_WON);
   assign move_count = mc_q;

endmodule

// File: tb/tb_maze_game_core.sv
// Self-checking bench for maze_game_core: directed scenarios plus randomized
// play checked against a move-level reference model of the maze rules.
module tb_maze_game_core;
   localparam int W  = 30;
   localparam int H  = 21;
   localparam int SE = 10;
   localparam int SM = 5;
   localparam int SH = 3;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         mv_up = 1'b0, mv_down = 1'b0, mv_left = 1'b0, mv_right = 1'b0, sel = 1'b0;
   logic [4:0]   map_addr;
   logic [W-1:0] map_row;
   logic [4:0]   player_x;
   logic [4:0]   player_y;
   logic [2:0]   state;
   logic [1:0]   difficulty;
   logic         show_map, lost, won;
   logic [15:0]  move_count;

   logic [W-1:0] rom [H];
   int checks   = 0;
   int failures = 0;
   int m_x, m_y, m_mc;
   int show_len [3] = '{SE, SM, SH};

   maze_game_core #(
      .MAP_W(W), .MAP_H(H), .START_X(0), .START_Y(20), .GOAL_X(29), .GOAL_Y(0),
      .SHOW_EASY(SE), .SHOW_MED(SM), .SHOW_HARD(SH)
   ) dut (
      .clk(clk), .reset(reset),
      .mv_up(mv_up), .mv_down(mv_down), .mv_left(mv_left), .mv_right(mv_right),
      .sel(sel), .map_addr(map_addr), .map_row(map_row),
      .player_x(player_x), .player_y(player_y), .state(state),
      .difficulty(difficulty), .show_map(show_map), .lost(lost), .won(won),
      .move_count(move_count)
   );

   always #5 clk = ~clk;

   // Combinational ROM: data for a new address is ready by the next edge.
   always_comb map_row = (map_addr < 5'd21) ? rom[map_addr] : '0;

   // All tasks start and end just after a falling edge.
   task automatic pulse(input logic u, input logic d, input logic l, input logic r, input logic s);
      mv_up = u; mv_down = d; mv_left = l; mv_right = r; sel = s;
      @(negedge clk);
      mv_up = 0; mv_down = 0; mv_left = 0; mv_right = 0; sel = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic clear_rom();
      for (int r = 0; r < H; r++) rom[r] = '0;
   endtask

   task automatic start_game(input int d);
      int n;
      do_reset();
      for (int i = 0; i < d; i++) pulse(0, 1, 0, 0, 0);
      pulse(0, 0, 0, 0, 1);
      n = 0;
      while (state === 3'd1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (state !== 3'd2) begin
         failures++;
         $display("FAIL start_game: state=%0d required=2 after %0d cycles", state, n);
      end
      m_x = 0; m_y = 20; m_mc = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({state, difficulty, player_x, player_y, move_count, map_addr, lost, won, show_map} !==
          {3'd0, 2'd0, 5'd0, 5'd20, 16'd0, 5'd20, 3'b000}) begin
         failures++;
         $display("FAIL reset_values: st=%0d diff=%0d pos=(%0d,%0d) mc=%0d addr=%0d l/w/s=%b%b%b required st=0 diff=0 pos=(0,20) mc=0 addr=20 l/w/s=000",
                  state, difficulty, player_x, player_y, move_count, map_addr, lost, won, show_map);
      end
      reset = 1'b0;
   endtask

   task automatic test_menu();
      int exp_d;
      int req [4] = '{1, 2, 0, 1};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         pulse(0, 1, 0, 0, 0);
         checks++;
         if (difficulty !== 2'(req[i])) begin
            failures++;
            $display("FAIL menu_down%0d: difficulty=%0d required=%0d", i, difficulty, req[i]);
         end
      end
      pulse(1, 0, 0, 0, 0);
      pulse(1, 0, 0, 0, 0);
      checks++;
      if (difficulty !== 2'd2) begin
         failures++;
         $display("FAIL menu_up_wrap: difficulty=%0d required=2", difficulty);
      end
      exp_d = 2;
      for (int i = 0; i < 20; i++) begin
         int k;
         k = int'($urandom_range(0, 3));
         pulse(k == 0, k == 1, k == 2, k == 3, 0);
         if (k == 0) exp_d = (exp_d + 2) % 3;
         if (k == 1) exp_d = (exp_d + 1) % 3;
         checks++;
         if (difficulty !== 2'(exp_d) || state !== 3'd0) begin
            failures++;
            $display("FAIL menu_random%0d: difficulty=%0d state=%0d required difficulty=%0d state=0",
                     i, difficulty, state, exp_d);
         end
      end
   endtask

   task automatic test_show();
      for (int d = 0; d < 3; d++) begin
         int n;
         do_reset();
         for (int i = 0; i < d; i++) pulse(0, 1, 0, 0, 0);
         pulse(0, 0, 0, 0, 1);
         n = 0;
         while (show_map === 1'b1 && n < 50) begin
            n++;
            mv_right = (n == 2);
            mv_up    = (n == 3);
            sel      = (n == 3);
            @(negedge clk);
         end
         mv_right = 0; mv_up = 0; sel = 0;
         checks++;
         if (n != show_len[d]) begin
            failures++;
            $display("FAIL show_len_d%0d: show_map cycles=%0d required=%0d", d, n, show_len[d]);
         end
         checks++;
         if ({state, player_x, player_y, move_count} !== {3'd2, 5'd0, 5'd20, 16'd0}) begin
            failures++;
            $display("FAIL show_exit_d%0d: st=%0d pos=(%0d,%0d) mc=%0d required st=2 pos=(0,20) mc=0",
                     d, state, player_x, player_y, move_count);
         end
      end
   endtask

   task automatic test_play_basic();
      clear_rom();
      start_game(0);
      pulse(0, 0, 0, 1, 0);
      checks++;
      if (state !== 3'd3 || map_addr !== 5'd20) begin
         failures++;
         $display("FAIL play_check_entry: st=%0d addr=%0d required st=3 addr=20", state, map_addr);
      end
      @(negedge clk);
      checks++;
      if ({state, player_x, player_y, move_count} !== {3'd2, 5'd1, 5'd20, 16'd1}) begin
         failures++;
         $display("FAIL play_right: st=%0d pos=(%0d,%0d) mc=%0d required st=2 pos=(1,20) mc=1",
                  state, player_x, player_y, move_count);
      end
      pulse(0, 0, 1, 0, 0);
      @(negedge clk);
      pulse(0, 0, 1, 0, 0);
      checks++;
      if ({state, player_x, move_count} !== {3'd2, 5'd0, 16'd2}) begin
         failures++;
         $display("FAIL play_left_edge: st=%0d x=%0d mc=%0d required st=2 x=0 mc=2",
                  state, player_x, move_count);
      end
      pulse(0, 1, 0, 0, 1);
      checks++;
      if ({state, player_y, move_count} !== {3'd2, 5'd20, 16'd2}) begin
         failures++;
         $display("FAIL play_down_edge: st=%0d y=%0d mc=%0d required st=2 y=20 mc=2",
                  state, player_y, move_count);
      end
   endtask

   task automatic test_lost();
      rom[19][0] = 1'b1;
      pulse(1, 0, 0, 0, 0);
      checks++;
      if (state !== 3'd3 || map_addr !== 5'd19) begin
         failures++;
         $display("FAIL lost_check: st=%0d addr=%0d required st=3 addr=19", state, map_addr);
      end
      @(negedge clk);
      checks++;
      if ({state, lost, won, player_x, player_y} !== {3'd4, 1'b1, 1'b0, 5'd0, 5'd20}) begin
         failures++;
         $display("FAIL lost_wall: st=%0d lost=%b won=%b pos=(%0d,%0d) required st=4 lost=1 won=0 pos=(0,20)",
                  state, lost, won, player_x, player_y);
      end
      pulse(0, 0, 0, 1, 0);
      pulse(0, 0, 0, 0, 1);
      checks++;
      if ({state, lost, player_x, player_y, move_count, difficulty} !== {3'd0, 1'b0, 5'd0, 5'd20, 16'd2, 2'd0}) begin
         failures++;
         $display("FAIL lost_to_menu: st=%0d lost=%b pos=(%0d,%0d) mc=%0d diff=%0d required st=0 lost=0 pos=(0,20) mc=2 diff=0",
                  state, lost, player_x, player_y, move_count, difficulty);
      end
      rom[19][0] = 1'b0;
   endtask

   task automatic test_check_drop();
      clear_rom();
      start_game(2);
      pulse(0, 0, 0, 1, 0);
      pulse(1, 0, 0, 1, 1);
      @(negedge clk);
      checks++;
      if ({state, player_x, player_y, move_count} !== {3'd2, 5'd1, 5'd20, 16'd1}) begin
         failures++;
         $display("FAIL check_drop: st=%0d pos=(%0d,%0d) mc=%0d required st=2 pos=(1,20) mc=1",
                  state, player_x, player_y, move_count);
      end
   endtask

   task automatic test_priority_win();
      clear_rom();
      start_game(1);
      pulse(1, 0, 0, 1, 0);
      @(negedge clk);
      checks++;
      if ({player_x, player_y} !== {5'd0, 5'd19}) begin
         failures++;
         $display("FAIL prio_up_right: pos=(%0d,%0d) required (0,19)", player_x, player_y);
      end
      pulse(0, 1, 1, 1, 0);
      @(negedge clk);
      checks++;
      if ({player_x, player_y} !== {5'd0, 5'd20}) begin
         failures++;
         $display("FAIL prio_down: pos=(%0d,%0d) required (0,20)", player_x, player_y);
      end
      pulse(0, 0, 1, 1, 0);
      checks++;
      if ({state, player_x, move_count} !== {3'd2, 5'd0, 16'd2}) begin
         failures++;
         $display("FAIL prio_left_blocks: st=%0d x=%0d mc=%0d required st=2 x=0 mc=2",
                  state, player_x, move_count);
      end
      for (int i = 0; i < 20; i++) begin pulse(1, 0, 0, 0, 0); @(negedge clk); end
      for (int i = 0; i < 29; i++) begin pulse(0, 0, 0, 1, 0); @(negedge clk); end
      checks++;
      if ({state, won, lost, player_x, player_y, move_count} !== {3'd5, 1'b1, 1'b0, 5'd29, 5'd0, 16'd51}) begin
         failures++;
         $display("FAIL win_goal: st=%0d won=%b lost=%b pos=(%0d,%0d) mc=%0d required st=5 won=1 lost=0 pos=(29,0) mc=51",
                  state, won, lost, player_x, player_y, move_count);
      end
      pulse(0, 1, 0, 0, 0);
      pulse(0, 0, 0, 0, 1);
      checks++;
      if ({state, won, player_x, player_y, difficulty, move_count} !== {3'd0, 1'b0, 5'd0, 5'd20, 2'd1, 16'd51}) begin
         failures++;
         $display("FAIL win_to_menu: st=%0d won=%b pos=(%0d,%0d) diff=%0d mc=%0d required st=0 won=0 pos=(0,20) diff=1 mc=51",
                  state, won, player_x, player_y, difficulty, move_count);
      end
   endtask

   task automatic test_random_play();
      for (int g = 0; g < 6; g++) begin
         bit done;
         for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) rom[r][c] = ($urandom_range(0, 4) == 0);
         rom[20][0] = 1'b0;
         start_game(int'($urandom_range(0, 2)));
         done = 0;
         for (int s = 0; s < 60 && !done; s++) begin
            logic [3:0] k;
            int dx, dy, tx, ty;
            bit any;
            k = 4'($urandom);
            if ($urandom_range(0, 3) == 0) k = 4'd0;
            any = 1; dx = 0; dy = 0;
            if      (k[3]) dy = -1;
            else if (k[2]) dy = 1;
            else if (k[1]) dx = -1;
            else if (k[0]) dx = 1;
            else           any = 0;
            tx = m_x + dx;
            ty = m_y + dy;
            pulse(k[3], k[2], k[1], k[0], ($urandom_range(0, 7) == 0));
            if (!any || tx < 0 || tx >= W || ty < 0 || ty >= H) begin
               checks++;
               if ({state, player_x, player_y, move_count} !== {3'd2, 5'(m_x), 5'(m_y), 16'(m_mc)}) begin
                  failures++;
                  $display("FAIL rand_idle g%0d s%0d: st=%0d pos=(%0d,%0d) mc=%0d required st=2 pos=(%0d,%0d) mc=%0d",
                           g, s, state, player_x, player_y, move_count, m_x, m_y, m_mc);
               end
            end else begin
               checks++;
               if (state !== 3'd3 || map_addr !== 5'(ty)) begin
                  failures++;
                  $display("FAIL rand_check g%0d s%0d: st=%0d addr=%0d required st=3 addr=%0d",
                           g, s, state, map_addr, ty);
               end
               @(negedge clk);
               if (rom[ty][tx]) begin
                  done = 1;
                  checks++;
                  if ({state, lost, player_x, player_y, move_count} !== {3'd4, 1'b1, 5'(m_x), 5'(m_y), 16'(m_mc)}) begin
                     failures++;
                     $display("FAIL rand_wall g%0d s%0d: st=%0d lost=%b pos=(%0d,%0d) mc=%0d required st=4 lost=1 pos=(%0d,%0d) mc=%0d",
                              g, s, state, lost, player_x, player_y, move_count, m_x, m_y, m_mc);
                  end
               end else begin
                  m_x = tx; m_y = ty; m_mc++;
                  done = (tx == 29 && ty == 0);
                  checks++;
                  if ({state, player_x, player_y, move_count} !== {(done ? 3'd5 : 3'd2), 5'(m_x), 5'(m_y), 16'(m_mc)}) begin
                     failures++;
                     $display("FAIL rand_step g%0d s%0d: st=%0d pos=(%0d,%0d) mc=%0d required st=%0d pos=(%0d,%0d) mc=%0d",
                              g, s, state, player_x, player_y, move_count, done ? 5 : 2, m_x, m_y, m_mc);
                  end
               end
            end
         end
      end
   endtask

   task automatic test_reset_midway();
      int n;
      clear_rom();
      start_game(0);
      pulse(0, 0, 0, 1, 0);
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({state, difficulty, player_x, player_y, move_count, map_addr, lost, won, show_map} !==
          {3'd0, 2'd0, 5'd0, 5'd20, 16'd0, 5'd20, 3'b000}) begin
         failures++;
         $display("FAIL reset_in_check: st=%0d diff=%0d pos=(%0d,%0d) mc=%0d addr=%0d l/w/s=%b%b%b required st=0 diff=0 pos=(0,20) mc=0 addr=20 l/w/s=000",
                  state, difficulty, player_x, player_y, move_count, map_addr, lost, won, show_map);
      end
      @(negedge clk);
      reset = 1'b0;
      pulse(0, 0, 0, 0, 1);
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      checks++;
      if (state !== 3'd0 || show_map !== 1'b0) begin
         failures++;
         $display("FAIL reset_in_show: st=%0d show_map=%b required st=0 show_map=0", state, show_map);
      end
      @(negedge clk);
      reset = 1'b0;
      pulse(0, 0, 0, 0, 1);
      n = 0;
      while (show_map === 1'b1 && n < 50) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n != SE) begin
         failures++;
         $display("FAIL show_after_reset: show_map cycles=%0d required=%0d", n, SE);
      end
   endtask

   initial begin
      clear_rom();
      @(negedge clk);
      test_reset();
      test_menu();
      test_show();
      test_play_basic();
      test_lost();
      test_check_drop();
      test_priority_win();
      test_random_play();
      test_reset_midway();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
